// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with valid/ready handshake, 2-entry skid buffer, flush and NOP bubbles.
// Optional statistics counters (stall_cnt, bubble_cnt) enabled by defining PIPE_STATS_EN.
module pipe_skid_stage #(
  parameter int unsigned     ARQ    = 16,
  parameter int unsigned     CTRL_W = 12,
  parameter logic [ARQ-1:0]  NOP    = ARQ'(16'h0000),
  parameter int unsigned     CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [ARQ-1:0]    up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [ARQ-1:0]    dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ARQ-1:0]    data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  localparam entry_t BUBBLE = '{data: NOP, ctrl: CTRL_W'(0)};

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   up_ready_q, dn_valid_q;
  logic   up_accept, dn_accept;

  assign up_accept = up_valid & up_ready_q;
  assign dn_accept = dn_valid_q & dn_ready;

  // State, storage and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= (state_d != FULL);
      dn_valid_q <= (state_d != EMPTY);
    end
  end

  // Next state; main is forced to the bubble value whenever the stage empties
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (up_accept) begin
          state_d = ONE;
          main_d  = '{data: up_data, ctrl: up_ctrl};
        end
      end
      ONE: begin
        if (up_accept && dn_accept) begin
          main_d = '{data: up_data, ctrl: up_ctrl};
        end else if (up_accept) begin
          state_d = FULL;
          skid_d  = '{data: up_data, ctrl: up_ctrl};
        end else if (dn_accept) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
      FULL: begin
        if (dn_accept) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
    end
  end

  assign up_ready  = up_ready_q;
  assign dn_valid  = dn_valid_q;
  assign dn_data   = main_q.data;
  assign dn_ctrl   = main_q.ctrl;
  assign occupancy = 2'(state_q);

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_q, bubble_q;

  // Saturating stall/bubble counters, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (dn_valid_q && !dn_ready && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (!dn_valid_q && (bubble_q != '1)) bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  // statistics disabled: no counter state
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus randomized traffic
// against a queue-based reference model (counters checked when PIPE_STATS_EN is defined).
module tb_pipe_skid_stage;
  localparam int unsigned ARQ    = 16;
  localparam int unsigned CTRL_W = 12;
  localparam int unsigned CNT_W  = 4;
  localparam logic [ARQ-1:0] NOP = 16'h7000;
  localparam int unsigned SAT    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              up_valid = 1'b0;
  logic              up_ready;
  logic [ARQ-1:0]    up_data = '0;
  logic [CTRL_W-1:0] up_ctrl = '0;
  logic              dn_valid;
  logic              dn_ready = 1'b0;
  logic [ARQ-1:0]    dn_data;
  logic [CTRL_W-1:0] dn_ctrl;
  logic [1:0]        occupancy;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.ARQ(ARQ), .CTRL_W(CTRL_W), .NOP(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_ctrl(up_ctrl),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data), .dn_ctrl(dn_ctrl),
    .occupancy(occupancy)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  // Reference model: a FIFO of at most two entries plus saturating counters
  typedef struct packed {
    logic [ARQ-1:0]    d;
    logic [CTRL_W-1:0] c;
  } ent_t;
  ent_t q[$];
  int unsigned m_stall = 0;
  int unsigned m_bubble = 0;

  function automatic logic [ARQ-1:0] exp_data();
    return (q.size() > 0) ? q[0].d : NOP;
  endfunction
  function automatic logic [CTRL_W-1:0] exp_ctrl();
    return (q.size() > 0) ? q[0].c : '0;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return at the following negedge
  task automatic step(input logic uv, input logic [ARQ-1:0] ud, input logic [CTRL_W-1:0] uc,
                      input logic dr, input logic fl);
    bit ua, da;
    up_valid = uv; up_data = ud; up_ctrl = uc; dn_ready = dr; flush = fl;
    @(posedge clk);
    ua = uv && (q.size() < 2);
    da = (q.size() > 0) && dr;
    if (q.size() > 0 && !dr && m_stall < SAT) m_stall++;
    if (q.size() == 0 && m_bubble < SAT) m_bubble++;
    if (da) void'(q.pop_front());
    if (ua) q.push_back('{d: ud, c: uc});
    if (fl) q.delete();
    @(negedge clk);
  endtask

  task automatic do_reset();
    up_valid = 1'b0; flush = 1'b0; dn_ready = 1'b0;
    rst = 1'b0;
    q.delete(); m_stall = 0; m_bubble = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({dn_valid, up_ready, dn_data, dn_ctrl, occupancy} !== {1'b0, 1'b1, NOP, CTRL_W'(0), 2'd0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b r=%b d=%h c=%h occ=%0d, want v=0 r=1 d=%h c=0 occ=0",
               dn_valid, up_ready, dn_data, dn_ctrl, occupancy, NOP);
    end
`ifdef PIPE_STATS_EN
    n_cmp++;
    if (stall_cnt !== '0 || bubble_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got stall=%0d bubble=%0d, want 0 0", stall_cnt, bubble_cnt);
    end
`endif
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, ARQ'(i), CTRL_W'(i + 16), 1'b1, 1'b0);
      n_cmp++;
      if (dn_valid !== 1'b1 || dn_data !== ARQ'(i) || dn_ctrl !== CTRL_W'(i + 16) || occupancy !== 2'd1) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b d=%h c=%h occ=%0d, want v=1 d=%h c=%h occ=1",
                 i, dn_valid, dn_data, dn_ctrl, occupancy, ARQ'(i), CTRL_W'(i + 16));
      end
    end
  endtask

  // Entry 5 is held in main; 6 lands in skid, 7 is refused while full
  task automatic test_stall_skid();
    step(1'b1, 16'd6, 12'd6, 1'b0, 1'b0);
    n_cmp++;
    if (occupancy !== 2'd2 || up_ready !== 1'b0 || dn_data !== 16'd5) begin
      n_fail++;
      $display("FAIL stall_fill: got occ=%0d r=%b d=%h, want occ=2 r=0 d=0005", occupancy, up_ready, dn_data);
    end
    repeat (2) step(1'b1, 16'd7, 12'd7, 1'b0, 1'b0);
    n_cmp++;
    if (occupancy !== 2'd2 || up_ready !== 1'b0 || dn_data !== 16'd5) begin
      n_fail++;
      $display("FAIL stall_hold: got occ=%0d r=%b d=%h, want occ=2 r=0 d=0005", occupancy, up_ready, dn_data);
    end
`ifdef PIPE_STATS_EN
    n_cmp++;
    if (stall_cnt !== CNT_W'(3)) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d, want 3", stall_cnt);
    end
`endif
    step(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (dn_valid !== 1'b1 || dn_data !== 16'd6 || dn_ctrl !== 12'd6 || occupancy !== 2'd1 || up_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release1: got v=%b d=%h occ=%0d r=%b, want v=1 d=0006 occ=1 r=1",
               dn_valid, dn_data, occupancy, up_ready);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (dn_valid !== 1'b0 || dn_data !== NOP || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_release2: got v=%b d=%h occ=%0d, want v=0 d=%h occ=0", dn_valid, dn_data, occupancy, NOP);
    end
  endtask

  task automatic test_flush_full();
    step(1'b1, 16'h0A0A, 12'h0AA, 1'b0, 1'b0);
    step(1'b1, 16'h0B0B, 12'h0BB, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 12'hFFF, 1'b0, 1'b1);
    n_cmp++;
    if ({dn_valid, up_ready, dn_data, dn_ctrl, occupancy} !== {1'b0, 1'b1, NOP, CTRL_W'(0), 2'd0}) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b r=%b d=%h c=%h occ=%0d, want v=0 r=1 d=%h c=0 occ=0",
               dn_valid, up_ready, dn_data, dn_ctrl, occupancy, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (dn_valid !== 1'b0 || dn_data === 16'hBEEF) begin
        n_fail++;
        $display("FAIL flush_leak[%0d]: got v=%b d=%h, want v=0 d=%h", i, dn_valid, dn_data, NOP);
      end
    end
  endtask

  // Accept in the flush cycle from ONE must be discarded
  task automatic test_flush_accept();
    step(1'b1, 16'h1111, 12'h111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 12'h222, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (dn_valid !== 1'b0 || occupancy !== 2'd0 || dn_data !== NOP) begin
      n_fail++;
      $display("FAIL flush_accept: got v=%b occ=%0d d=%h, want v=0 occ=0 d=%h", dn_valid, occupancy, dn_data, NOP);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h5555, 12'h555, 1'b1, 1'b0);
      n_cmp++;
      if (dn_valid !== 1'b0 || dn_data !== NOP || dn_ctrl !== '0) begin
        n_fail++;
        $display("FAIL bubble[%0d]: got v=%b d=%h c=%h, want v=0 d=%h c=0", i, dn_valid, dn_data, dn_ctrl, NOP);
      end
    end
`ifdef PIPE_STATS_EN
    n_cmp++;
    if (bubble_cnt !== CNT_W'(4)) begin
      n_fail++;
      $display("FAIL bubble_cnt: got %0d, want 4", bubble_cnt);
    end
`endif
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'h0C0C, 12'h00C, 1'b0, 1'b0);
    step(1'b1, 16'h0D0D, 12'h00D, 1'b0, 1'b0);
    up_valid = 1'b0;
    #2 rst = 1'b0;
    q.delete(); m_stall = 0; m_bubble = 0;
    #1;
    n_cmp++;
    if ({dn_valid, up_ready, dn_data, dn_ctrl, occupancy} !== {1'b0, 1'b1, NOP, CTRL_W'(0), 2'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b r=%b d=%h c=%h occ=%0d, want v=0 r=1 d=%h c=0 occ=0",
               dn_valid, up_ready, dn_data, dn_ctrl, occupancy, NOP);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 16'h0E0E, 12'h00E, 1'b1, 1'b0);
    n_cmp++;
    if (dn_valid !== 1'b1 || dn_data !== 16'h0E0E || occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL async_resume: got v=%b d=%h occ=%0d, want v=1 d=0e0e occ=1", dn_valid, dn_data, occupancy);
    end
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_saturation();
    do_reset();
    step(1'b1, 16'h00AA, 12'h0AA, 1'b0, 1'b0);
    repeat (20) step(1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (stall_cnt !== CNT_W'(SAT)) begin
      n_fail++;
      $display("FAIL stall_sat: got %0d, want %0d", stall_cnt, SAT);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), ARQ'($urandom), CTRL_W'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      n_cmp++;
      if ({dn_valid, up_ready, dn_data, dn_ctrl, occupancy} !==
          {q.size() > 0, q.size() < 2, exp_data(), exp_ctrl(), 2'(q.size())}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b r=%b d=%h c=%h occ=%0d, want v=%b r=%b d=%h c=%h occ=%0d",
                 i, dn_valid, up_ready, dn_data, dn_ctrl, occupancy,
                 q.size() > 0, q.size() < 2, exp_data(), exp_ctrl(), q.size());
      end
`ifdef PIPE_STATS_EN
      n_cmp++;
      if (stall_cnt !== CNT_W'(m_stall) || bubble_cnt !== CNT_W'(m_bubble)) begin
        n_fail++;
        $display("FAIL random_cnt[%0d]: got stall=%0d bubble=%0d, want stall=%0d bubble=%0d",
                 i, stall_cnt, bubble_cnt, m_stall, m_bubble);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush_full();
    test_flush_accept();
    test_bubble();
    test_async_reset();
`ifdef PIPE_STATS_EN
    test_saturation();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
